// File: rtl/mem_wb_skid.sv
// MEM->WB stage: LANES register writes per beat through a main+skid buffer with registered in_ready.
// One-cycle latency; forwarding looks into held beats, youngest (skid, highest lane) first.
module mem_wb_skid #(
   parameter int LANES = 2,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES-1:0]    in_we,
   input  logic [LANES*AW-1:0] in_rd,
   input  logic [LANES*DW-1:0] in_val,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES-1:0]    out_we,
   output logic [LANES*AW-1:0] out_rd,
   output logic [LANES*DW-1:0] out_val,
   input  logic [AW-1:0]       fwd_addr,
   output logic                fwd_hit,
   output logic [DW-1:0]       fwd_val,
   output logic [CNT_W-1:0]    retire_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic                skid_vld;
   logic [LANES-1:0]    skid_we;
   logic [LANES*AW-1:0] skid_rd;
   logic [LANES*DW-1:0] skid_val;
   logic [LANES-1:0]    cap_we;
   logic                accept;
   logic                consume;
   logic                main_free;

   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
   assign main_free = !out_valid || consume;

   // Writes to x0 are dropped at capture so neither the regfile nor forwarding sees them.
   always_comb begin
      cap_we = '0;
      for (int i = 0; i < LANES; i++)
         cap_we[i] = in_we[i] && (in_rd[i*AW +: AW] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_we     <= '0;
         out_rd     <= '0;
         out_val    <= '0;
         skid_vld   <= 1'b0;
         skid_we    <= '0;
         skid_rd    <= '0;
         skid_val   <= '0;
         in_ready   <= 1'b1;
         retire_cnt <= '0;
      end else begin
         if (consume)
            retire_cnt <= retire_cnt + CNT_ONE;
         if (flush) begin
            out_valid <= 1'b0;
            out_we    <= '0;
            skid_vld  <= 1'b0;
            in_ready  <= 1'b1;
         end else if (main_free) begin
            if (skid_vld) begin
               out_valid <= 1'b1;
               out_we    <= skid_we;
               out_rd    <= skid_rd;
               out_val   <= skid_val;
               skid_vld  <= 1'b0;
               in_ready  <= 1'b1;
            end else if (accept) begin
               out_valid <= 1'b1;
               out_we    <= cap_we;
               out_rd    <= in_rd;
               out_val   <= in_val;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            // Main is stalled: park the beat and stop accepting until the skid drains.
            skid_vld <= 1'b1;
            skid_we  <= cap_we;
            skid_rd  <= in_rd;
            skid_val <= in_val;
            in_ready <= 1'b0;
         end
      end
   end

   // Later matches override earlier ones: main then skid, low lane then high lane.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_val = '0;
      if (fwd_addr != '0) begin
         for (int i = 0; i < LANES; i++) begin
            if (out_valid && out_we[i] && out_rd[i*AW +: AW] == fwd_addr) begin
               fwd_hit = 1'b1;
               fwd_val = out_val[i*DW +: DW];
            end
         end
         for (int i = 0; i < LANES; i++) begin
            if (skid_vld && skid_we[i] && skid_rd[i*AW +: AW] == fwd_addr) begin
               fwd_hit = 1'b1;
               fwd_val = skid_val[i*DW +: DW];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: directed scenarios then random traffic against a queue-based model.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_mem_wb_skid;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [1:0]  in_we;
   logic [9:0]  in_rd;
   logic [63:0] in_val;
   logic [4:0]  fwd_addr;
   logic        in_ready, out_valid, fwd_hit;
   logic [1:0]  out_we;
   logic [9:0]  out_rd;
   logic [63:0] out_val;
   logic [31:0] fwd_val, retire_cnt;
   logic        d4_in_ready, d4_out_valid, d4_fwd_hit;
   logic [1:0]  d4_out_we;
   logic [9:0]  d4_out_rd;
   logic [63:0] d4_out_val;
   logic [31:0] d4_fwd_val;
   logic [3:0]  retire_cnt4;

   always #5 clk = ~clk;

   mem_wb_skid dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_we(in_we), .in_rd(in_rd), .in_val(in_val), .out_valid(out_valid),
      .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd), .out_val(out_val),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_val(fwd_val), .retire_cnt(retire_cnt)
   );

   mem_wb_skid #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d4_in_ready),
      .in_we(in_we), .in_rd(in_rd), .in_val(in_val), .out_valid(d4_out_valid),
      .out_ready(out_ready), .out_we(d4_out_we), .out_rd(d4_out_rd), .out_val(d4_out_val),
      .fwd_addr(fwd_addr), .fwd_hit(d4_fwd_hit), .fwd_val(d4_fwd_val), .retire_cnt(retire_cnt4)
   );

   typedef struct {
      logic [1:0]  we;
      logic [9:0]  rd;
      logic [63:0] val;
   } beat_t;

   beat_t       q[$];
   bit          rdy_m;
   int unsigned cnt_m;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_beat(input logic [1:0] we, input logic [4:0] r0, input logic [31:0] v0,
                           input logic [4:0] r1, input logic [31:0] v1);
      in_we  = we;
      in_rd  = {r1, r0};
      in_val = {v1, v0};
   endtask

   // Checks outputs mid-cycle against the model, then advances the model across the edge.
   task automatic step();
      beat_t       b;
      bit          cons, acc, hit;
      logic [31:0] fv;
      @(negedge clk);
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, rdy_m);
      check("retire_cnt", retire_cnt, cnt_m);
      check("retire_cnt4", retire_cnt4, cnt_m % 16);
      if (q.size() > 0) begin
         check("out_we", out_we, q[0].we);
         check("out_rd", out_rd, q[0].rd);
         check("out_val", out_val, q[0].val);
      end
      hit = 0;
      fv  = '0;
      if (fwd_addr != 0) begin
         for (int e = q.size() - 1; e >= 0; e--)
            for (int l = 1; l >= 0; l--)
               if (!hit && q[e].we[l] && q[e].rd[l*5 +: 5] == fwd_addr) begin
                  hit = 1;
                  fv  = q[e].val[l*32 +: 32];
               end
      end
      check("fwd_hit", fwd_hit, hit);
      check("fwd_val", fwd_val, fv);
      cons = (q.size() > 0) && out_ready;
      acc  = in_valid && rdy_m;
      if (rst) begin
         q.delete();
         rdy_m = 1;
         cnt_m = 0;
      end else begin
         if (cons) cnt_m++;
         if (flush) begin
            q.delete();
            rdy_m = 1;
         end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
               b.rd  = in_rd;
               b.val = in_val;
               for (int l = 0; l < 2; l++)
                  b.we[l] = in_we[l] && (in_rd[l*5 +: 5] != 0);
               q.push_back(b);
            end
            rdy_m = q.size() < 2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; fwd_addr = 0;
      set_beat(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rdy_m = 1; cnt_m = 0;
      step();
      check("rst_out_we", out_we, 2'b00);
      check("rst_out_rd", out_rd, 10'd0);
      check("rst_out_val", out_val, 64'd0);
      rst = 0;

      // Back-to-back beats at full throughput.
      out_ready = 1; in_valid = 1; fwd_addr = 5'd4;
      set_beat(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
      repeat (6) step();
      check("t1_in_ready", in_ready, 1'b1);
      in_valid = 0;
      step();

      // Stall: A to main, B to skid, C held by the source.
      out_ready = 0; in_valid = 1;
      set_beat(2'b11, 5'd1, 32'hA0, 5'd2, 32'hA1); step();
      set_beat(2'b11, 5'd1, 32'hB0, 5'd2, 32'hB1); step();
      set_beat(2'b11, 5'd1, 32'hC0, 5'd2, 32'hC1); step();
      check("t2_in_ready", in_ready, 1'b0);
      check("t2_head", out_val[31:0], 32'hA0);
      step();
      out_ready = 1;
      step(); step();
      in_valid = 0;
      step(); step();

      // x0 write suppression.
      flush = 1; step(); flush = 0;
      out_ready = 0; in_valid = 1; fwd_addr = 5'd0;
      set_beat(2'b11, 5'd0, 32'hDEAD, 5'd7, 32'h1); step();
      in_valid = 0;
      check("t3_we0", out_we[0], 1'b0);
      check("t3_fwd0", fwd_hit, 1'b0);
      step();

      // Forwarding priority: skid lane1 over skid lane0 over main.
      flush = 1; step(); flush = 0;
      in_valid = 1; fwd_addr = 5'd5;
      set_beat(2'b01, 5'd5, 32'h1, 5'd0, 32'h0); step();
      set_beat(2'b11, 5'd5, 32'h2, 5'd5, 32'h3); step();
      in_valid = 0;
      check("t4_hit", fwd_hit, 1'b1);
      check("t4_val", fwd_val, 32'h3);
      out_ready = 1; step(); out_ready = 0;
      check("t4_val_main", fwd_val, 32'h3);
      step();

      // Flush while full with a beat offered.
      in_valid = 1;
      set_beat(2'b01, 5'd6, 32'h66, 5'd0, 32'h0); step();
      check("t5_full", in_ready, 1'b0);
      flush = 1;
      set_beat(2'b01, 5'd5, 32'h77, 5'd0, 32'h0); step();
      flush = 0; in_valid = 0;
      check("t5_out_valid", out_valid, 1'b0);
      check("t5_in_ready", in_ready, 1'b1);
      check("t5_fwd_hit", fwd_hit, 1'b0);
      check("t5_out_we", out_we, 2'b00);
      out_ready = 1;
      repeat (3) step();

      // 17 consumes wrap a 4-bit counter to 1; then reset while full.
      rst = 1; step(); rst = 0;
      in_valid = 1;
      set_beat(2'b11, 5'd9, 32'h99, 5'd10, 32'hAA);
      repeat (17) step();
      in_valid = 0;
      step();
      check("t6_cnt4", retire_cnt4, 4'd1);
      check("t6_cnt32", retire_cnt, 32'd17);
      out_ready = 0; in_valid = 1;
      step(); step();
      rst = 1; step();
      rst = 0; in_valid = 0;
      check("t6_rst_valid", out_valid, 1'b0);
      check("t6_rst_we", out_we, 2'b00);
      check("t6_rst_rd", out_rd, 10'd0);
      check("t6_rst_val", out_val, 64'd0);
      check("t6_rst_ready", in_ready, 1'b1);
      check("t6_rst_cnt", retire_cnt, 32'd0);
      check("t6_rst_hit", fwd_hit, 1'b0);

      // Random traffic with rd collisions, occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 9) < 7);
         fwd_addr  = 5'($urandom_range(0, 7));
         set_beat(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
